// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of one port of the byte-lane block RAM.
// Each transaction walks IDLE -> ISSUE -> WAIT -> ACK. An out-of-range address
// jumps straight from IDLE to ACK with an error and never touches the RAM.
// Every output comes from a flop; the next values are computed alongside the
// next state.
module ram_port_arbiter #(
  parameter int unsigned SIZE = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        m0_stb_i,
  input  logic [29:0] m0_addr_i,
  input  logic [3:0]  m0_wr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_stb_i,
  input  logic [29:0] m1_addr_i,
  input  logic [3:0]  m1_wr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        ram_en_o,
  output logic [3:0]  ram_we_o,
  output logic [29:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  // One extra bit so a SIZE of 2^30 still compares correctly; addresses never wrap.
  localparam logic [30:0] SIZE_W = 31'(SIZE);

  state_t state_q, state_d;
  logic   last_q, last_d;   // last granted requester; 1 = m1
  logic   gnt_q, gnt_d;     // requester owning the current transaction
  logic   gsel;

  logic [1:0]        stb;
  logic [1:0][29:0]  maddr;
  logic [1:0][3:0]   mwr;
  logic [1:0][31:0]  mdat;

  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [1:0][31:0]  rdat_q, rdat_d;

  logic              ram_en_d;
  logic [3:0]        ram_we_d;
  logic [29:0]       ram_addr_d;
  logic [31:0]       ram_data_d;

  assign stb   = {m1_stb_i, m0_stb_i};
  assign maddr = {m1_addr_i, m0_addr_i};
  assign mwr   = {m1_wr_i, m0_wr_i};
  assign mdat  = {m1_data_i, m0_data_i};

  assign m0_ack_o  = ack_q[0];
  assign m1_ack_o  = ack_q[1];
  assign m0_err_o  = err_q[0];
  assign m1_err_o  = err_q[1];
  assign m0_data_o = rdat_q[0];
  assign m1_data_o = rdat_q[1];

  // Requester choice: a lone request wins outright, a tie goes to whoever was not granted last.
  always_comb begin
    gsel = stb[1];
    if (&stb) gsel = ~last_q;
  end

  // Next state plus next value of every registered output.
  // The RAM address/data registers double as the latched request: they are loaded
  // on grant and held, so ISSUE presents exactly what the requester asked for.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    ram_en_d   = 1'b0;
    ram_we_d   = 4'h0;
    ram_addr_d = ram_addr_o;
    ram_data_d = ram_data_o;
    ack_d      = 2'b00;
    err_d      = 2'b00;
    rdat_d     = '0;
    case (state_q)
      IDLE: begin
        if (|stb) begin
          gnt_d  = gsel;
          last_d = gsel;
          if ({1'b0, maddr[gsel]} >= SIZE_W) begin
            state_d      = ACK;
            ack_d[gsel]  = 1'b1;
            err_d[gsel]  = 1'b1;
          end else begin
            state_d    = ISSUE;
            ram_en_d   = 1'b1;
            ram_we_d   = mwr[gsel];
            ram_addr_d = maddr[gsel];
            ram_data_d = mdat[gsel];
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // RAM output is valid now (one cycle after enable); it becomes the response.
        state_d        = ACK;
        ack_d[gnt_q]   = 1'b1;
        rdat_d[gnt_q]  = ram_data_i;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and arbitration history.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  // Output registers; reset clears them at once, aborting any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ram_en_o   <= 1'b0;
      ram_we_o   <= 4'h0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      rdat_q     <= '0;
    end else begin
      ram_en_o   <= ram_en_d;
      ram_we_o   <= ram_we_d;
      ram_addr_o <= ram_addr_d;
      ram_data_o <= ram_data_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdat_q     <= rdat_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a byte-lane RAM model behind the port,
// per-requester expectation queues filled at issue time, and a monitor that
// pops and compares whenever an ack appears.
module tb_ram_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        m0_stb_i = 1'b0, m1_stb_i = 1'b0;
  logic [29:0] m0_addr_i = '0, m1_addr_i = '0;
  logic [3:0]  m0_wr_i = '0, m1_wr_i = '0;
  logic [31:0] m0_data_i = '0, m1_data_i = '0;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic        ram_en_o;
  logic [3:0]  ram_we_o;
  logic [29:0] ram_addr_o;
  logic [31:0] ram_data_o;
  logic [31:0] ram_data_i = '0;

  int errors = 0;
  int checks = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  int          order[$];
  bit          en_seen = 0;
  logic [31:0] mem [0:1023];

  ram_port_arbiter #(.SIZE(1024)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_stb_i(m0_stb_i), .m0_addr_i(m0_addr_i), .m0_wr_i(m0_wr_i), .m0_data_i(m0_data_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_stb_i(m1_stb_i), .m1_addr_i(m1_addr_i), .m1_wr_i(m1_wr_i), .m1_data_i(m1_data_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Write-first byte-lane RAM with a registered read port.
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      mem[ram_addr_o[9:0]] <= merge(mem[ram_addr_o[9:0]], ram_data_o, ram_we_o);
      ram_data_i           <= merge(mem[ram_addr_o[9:0]], ram_data_o, ram_we_o);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops that requester's expectation; outside acks the response is 0.
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk_i);
      if (ram_en_o) en_seen = 1;
      if (m0_ack_o && m1_ack_o) chk("dual_ack", 1, 0);
      if (m0_ack_o) begin
        order.push_back(0);
        if (q0.size() == 0) chk("m0_unexpected_ack", 1, 0);
        else begin
          e = q0.pop_front();
          chk("m0_data", 64'(m0_data_o), 64'(e[31:0]));
          chk("m0_err", 64'(m0_err_o), 64'(e[32]));
        end
      end else chk("m0_idle_resp", {m0_err_o, m0_data_o}, 0);
      if (m1_ack_o) begin
        order.push_back(1);
        if (q1.size() == 0) chk("m1_unexpected_ack", 1, 0);
        else begin
          e = q1.pop_front();
          chk("m1_data", 64'(m1_data_o), 64'(e[31:0]));
          chk("m1_err", 64'(m1_err_o), 64'(e[32]));
        end
      end else chk("m1_idle_resp", {m1_err_o, m1_data_o}, 0);
    end
  end

  // One master transaction. Called just after a rising edge; returns just after the
  // rising edge that follows the ack, with stb dropped unless hold is set.
  task automatic xfer(input int m, input logic [29:0] a, input logic [3:0] w,
                      input logic [31:0] d, input logic [31:0] ed, input logic ee,
                      input bit hold, input bit lat, input int lim);
    int k;
    bit got;
    if (m == 0) begin
      m0_stb_i = 1; m0_addr_i = a; m0_wr_i = w; m0_data_i = d; q0.push_back({ee, ed});
    end else begin
      m1_stb_i = 1; m1_addr_i = a; m1_wr_i = w; m1_data_i = d; q1.push_back({ee, ed});
    end
    k = 0;
    got = 0;
    while (!got && k < lim) begin
      @(negedge clk_i);
      k++;
      if (lat && !ee && k == 2) begin
        chk("issue_en", 64'(ram_en_o), 1);
        chk("issue_we", 64'(ram_we_o), 64'(w));
        chk("issue_addr", 64'(ram_addr_o), 64'(a));
        chk("issue_data", 64'(ram_data_o), 64'(d));
      end
      if (lat && !ee && k == 3) chk("wait_en_we", {ram_en_o, ram_we_o}, 0);
      got = (m == 0) ? m0_ack_o : m1_ack_o;
    end
    if (!got) chk("ack_timeout", 64'(k), 0);
    else if (lat) chk("ack_latency", 64'(k), ee ? 2 : 4);
    @(posedge clk_i);
    #1;
    if (!hold) begin
      if (m == 0) m0_stb_i = 0; else m1_stb_i = 0;
    end
  endtask

  task automatic seq(input int m, input logic [29:0] base, input logic [31:0] dbase);
    for (int i = 0; i < 4; i++)
      xfer(m, base + 30'(i), 4'hF, dbase + 32'(i), dbase + 32'(i), 0, i < 3, 0, 12);
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // reset state
    #3;
    chk("reset_outputs", {ram_en_o, ram_we_o, ram_addr_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    chk("reset_data", {m0_data_o, m1_data_o}, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1;
    @(posedge clk_i); #1;

    // single write then read
    xfer(0, 30'h10, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 10);
    xfer(0, 30'h10, 4'h0, 32'h0, 32'hDEADBEEF, 0, 0, 1, 10);

    // byte lanes
    xfer(0, 30'h20, 4'hF, 32'h11223344, 32'h11223344, 0, 0, 1, 10);
    xfer(0, 30'h20, 4'h2, 32'h0000AB00, 32'h1122AB44, 0, 0, 1, 10);
    xfer(0, 30'h20, 4'h0, 32'h0, 32'h1122AB44, 0, 0, 1, 10);

    // out of range: exactly SIZE, and the top of the 30-bit space (would alias 0x3FF if wrapped)
    en_seen = 0;
    xfer(1, 30'h400, 4'h0, 32'h0, 32'h0, 1, 0, 1, 10);
    xfer(1, 30'h3FFFFFFF, 4'hF, 32'h55AA55AA, 32'h0, 1, 0, 1, 10);
    chk("err_no_ram_access", 64'(en_seen), 0);
    xfer(1, 30'h3FF, 4'h0, 32'h0, 32'h0, 0, 0, 1, 10);

    // contention: last grant was m1, so m0 goes first and grants alternate
    order.delete();
    fork
      seq(0, 30'h40, 32'hA0);
      seq(1, 30'h80, 32'hB0);
    join
    chk("contention_count", 64'(order.size()), 8);
    for (int i = 0; i < 8 && i < order.size(); i++) chk("grant_order", 64'(order[i]), 64'(i % 2));
    xfer(0, 30'h43, 4'h0, 32'h0, 32'hA3, 0, 0, 1, 10);
    xfer(1, 30'h83, 4'h0, 32'h0, 32'hB3, 0, 0, 1, 10);

    // back-to-back: new request presented on the edge right after ack
    xfer(0, 30'h50, 4'hF, 32'h12345678, 32'h12345678, 0, 1, 1, 10);
    xfer(0, 30'h51, 4'hF, 32'h9ABCDEF0, 32'h9ABCDEF0, 0, 0, 1, 10);
    xfer(0, 30'h50, 4'h0, 32'h0, 32'h12345678, 0, 0, 1, 10);
    xfer(0, 30'h51, 4'h0, 32'h0, 32'h9ABCDEF0, 0, 0, 1, 10);

    // reset in the middle of ISSUE
    m0_stb_i = 1; m0_addr_i = 30'h10; m0_wr_i = 4'h0; m0_data_i = '0;
    got = 0;
    for (int k = 0; k < 6 && !got; k++) begin
      @(negedge clk_i);
      got = ram_en_o;
    end
    chk("reached_issue", 64'(got), 1);
    rst_n_i = 0;
    #1;
    chk("midrst_outputs", {ram_en_o, ram_we_o, ram_addr_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    chk("midrst_data", {ram_data_o, m0_data_o, m1_data_o}, 0);
    m0_stb_i = 0;
    @(posedge clk_i);
    #1 rst_n_i = 1;
    repeat (6) @(posedge clk_i);
    #1;
    xfer(0, 30'h10, 4'h0, 32'h0, 32'hDEADBEEF, 0, 0, 1, 10);

    repeat (3) @(posedge clk_i);
    chk("queues_drained", 64'(q0.size() + q1.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one port of the byte-lane dual-port block RAM between two bus requesters, m0 and m1, for example a CPU data bus and a loader/DMA engine.
- Uses round-robin arbitration and a registered, fixed-latency transaction FSM.
- Drives the RAM port signals (enable, per-byte write strobes, word address, write data) and returns read data with a one-cycle ack pulse.
- Rejects out-of-range word addresses with an error ack and issues no RAM access for them.

Parameters:
- SIZE, 1024: RAM depth in 32-bit words. Valid word addresses are 0..SIZE-1.

Ports:
- clk_i  in  1  single clock; all logic on the rising edge.
- rst_n_i  in  1  reset, asynchronous and active-low.
- m0_stb_i  in  1  m0 request; held until m0_ack_o.
- m0_addr_i  in  30  m0 word address [31:2].
- m0_wr_i  in  4  m0 byte write strobes; [3] = bits 31:24; 0 = read.
- m0_data_i  in  32  m0 write data.
- m0_data_o  out  32  m0 read data; valid while m0_ack_o = 1.
- m0_ack_o  out  1  m0 completion, one-cycle pulse.
- m0_err_o  out  1  m0 address error; qualified by m0_ack_o.
- m1_stb_i, m1_addr_i, m1_wr_i, m1_data_i, m1_data_o, m1_ack_o, m1_err_o: same as m0, for m1.
- ram_en_o  out  1  RAM port enable.
- ram_we_o  out  4  RAM byte write enables.
- ram_addr_o  out  30  RAM word address.
- ram_data_o  out  32  RAM write data.
- ram_data_i  in  32  RAM read data; registered, one cycle after enable.

Behaviour:
- Reset: every output is 0, state = IDLE, last_grant = m1 (so m0 wins the first tie). Reset asserted mid-transaction aborts it immediately; no ack is issued.
- FSM states: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- IDLE, no stb: stay in IDLE, ram_en_o = 0.
- IDLE, one stb: grant that requester.
- IDLE, both stb: grant the requester that is not last_grant, then update last_grant.
- Grant in IDLE: latch the granted addr, wr and data into working registers.
  - If addr >= SIZE: set error flag, go to ACK, no RAM access.
  - Otherwise: go to ISSUE.
- ISSUE: ram_en_o = 1, ram_we_o = latched wr, ram_addr_o and ram_data_o = latched values. Lasts exactly one cycle, then WAIT.
- WAIT: ram_en_o = 0 and ram_we_o = 0. Capture ram_data_i into the response register (for writes this is the write-through data). Then ACK.
- ACK: the granted requester sees ack_o = 1, data_o = captured word, err_o = error flag. Next state is always IDLE.
- Error ack returns data_o = 0.
- Outside ACK: all ack/err are 0 and data_o holds 0.
- Latency: stb sampled at edge N gives ack high during cycle N+3 (N+1 for an address error). Peak throughput is one transaction per 4 cycles.
- Master rules:
  - stb, addr, wr and data stay stable until ack.
  - After seeing ack, the master deasserts stb or presents a new request on the next edge. IDLE then samples it, so there is no double-service.
- A requester dropping stb before ack is a protocol violation. The arbiter still completes the latched transaction and pulses ack.
- A request arriving while busy waits; it is never lost.
- Round-robin means that under continuous contention grants strictly alternate m0, m1, m0, and so on.
- Address compare is unsigned over the full 30 bits; addresses at or above SIZE never wrap.

Test Plan:
- Reset values: assert rst_n_i mid-ISSUE → all outputs 0 asynchronously; after release state is IDLE and no spurious ack appears.
- Single write then read:
  - m0 writes addr 0x10, data 0xDEADBEEF, wr 0xF → ram_en_o/ram_we_o = 0xF at N+1, m0_ack_o at N+3.
  - m0 reads 0x10 → m0_data_o = 0xDEADBEEF, m0_err_o = 0.
- Byte lanes: write wr = 0x2, data 0x0000AB00 over 0x11223344, then read → 0x1122AB44.
- Contention: m0 and m1 both hold stb for 4 transactions each → grant order m0, m1, m0, m1, …; each ack is one cycle; no requester waits more than one other transaction.
- Out of range: m1 reads addr = SIZE (0x400) → m1_ack_o = 1 and m1_err_o = 1 at N+1, m1_data_o = 0, ram_en_o never asserted.
- Back-to-back: m0 re-asserts stb the cycle after ack with a new address → serviced with 4-cycle spacing; the old transaction is not repeated.
